// File: rtl/keypad_time_loader_pkg.sv
// Shared key codes, FSM state encoding and entry limits for the keypad timer loader.
package timer_pkg;

  localparam logic [3:0] KEY_START    = 4'hA;
  localparam logic [3:0] KEY_CANCEL   = 4'hB;
  localparam int         MAX_SEC_TENS = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_time_loader_if.sv
// Keypad-side inputs plus the preset/load/enable bundle that feeds the digit chain.
interface keypad_time_loader_if #(parameter int NDIG = 3);

  logic              key_valid;
  logic [3:0]        key_code;
  logic              timer_zero;
  logic [4*NDIG-1:0] data;
  logic              loadn;
  logic              en_count;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output key_valid, key_code, timer_zero,
    input  data, loadn, en_count, done, err, busy
  );

  modport slave (
    input  key_valid, key_code, timer_zero,
    output data, loadn, en_count, done, err, busy
  );

endinterface

// File: rtl/keypad_time_loader_key_filter.sv
// key_valid synchroniser and one-pulse-per-press edge detector; optional stability
// filter when KEYPAD_DEBOUNCE_EN is defined (adds DEBOUNCE_CYCLES of latency).
module key_filter
`ifdef KEYPAD_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic clear,
  input  logic key_valid,
  output logic key_evt
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], key_valid};
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt_q;
  logic          filt_q;

  // The counter only advances while the synchronised level disagrees with the filtered one.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q <= '0;
      filt_q   <= sync_q[1];
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign key_evt = level & ~level_q;

endmodule

// File: rtl/keypad_time_loader.sv
// Keypad entry buffer and load/run sequencer for the BCD down-counter chain.
// Optional key debounce filter under KEYPAD_DEBOUNCE_EN.
module keypad_time_loader
  import timer_pkg::*;
#(
  parameter int NDIG = 3
`ifdef KEYPAD_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
)(
  input  logic                 clk,
  input  logic                 clear,
  keypad_time_loader_if.slave  bus
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  state_t         state_q, state_d;
  logic [W-1:0]   buf_q, buf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           loadn_q, loadn_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           key_evt;
  logic           is_dig, is_start, is_cancel;
  logic [3:0]     code;
  logic [3:0]     sec_tens;

  key_filter
`ifdef KEYPAD_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
  u_key_filter (
    .clk       (clk),
    .clear     (clear),
    .key_valid (bus.key_valid),
    .key_evt   (key_evt)
  );

  assign code      = bus.key_code;
  assign is_dig    = key_evt && is_digit(code);
  assign is_start  = key_evt && (code == KEY_START);
  assign is_cancel = key_evt && (code == KEY_CANCEL);
  assign sec_tens  = buf_q[7:4];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      loadn_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      loadn_q <= loadn_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_dig) begin
          buf_d   = {buf_q[W-5:0], code};
          cnt_d   = CW'(1);
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        // A full buffer keeps its leading digit; extra digits are dropped.
        if (is_dig) begin
          if (cnt_q < CW'(NDIG)) begin
            buf_d = {buf_q[W-5:0], code};
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_cancel) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (is_start && (buf_q != '0)) begin
          if (sec_tens > 4'(MAX_SEC_TENS)) err_d = 1'b1;
          else                             state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Reaching zero outranks a simultaneous cancel.
        if (bus.timer_zero) begin
          state_d = DONE;
        end else if (is_cancel) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      DONE: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    loadn_d      = (state_d != LOAD);
    done_d       = (state_d == DONE);
    busy_d       = (state_d == LOAD) || (state_d == RUN) || (state_d == DONE);
    bus.en_count = (state_q == RUN) && !bus.timer_zero;
  end

  assign bus.data  = buf_q;
  assign bus.loadn = loadn_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Directed keypad sequences against a BCD mm:ss chain model; load/done/err events scoreboarded.
module tb_keypad_time_loader;

  localparam int EV_LOAD = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int          kind;
    logic [11:0] data;
  } ev_t;

  logic        clk;
  logic        clear;
  logic [11:0] chain;
  int          tests;
  int          fails;
  ev_t         exp_q[$];

  keypad_time_loader_if #(.NDIG(3)) bus();

  keypad_time_loader dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 != 4'd0) d0 = d0 - 4'd1;
    else begin
      d0 = 4'd9;
      if (d1 != 4'd0) d1 = d1 - 4'd1;
      else begin
        d1 = 4'd5;
        d2 = d2 - 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  // Digit chain model: load on loadn low, count down while enabled.
  always @(posedge clk or posedge clear) begin
    if (clear)                  chain <= 12'h000;
    else if (!bus.loadn)        chain <= bus.data;
    else if (bus.en_count)      chain <= bcd_dec(chain);
  end
  assign bus.timer_zero = (chain == 12'h000);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [11:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [11:0] data);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got kind %0d data %0h, expected no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != EV_DONE && e.data !== data)) begin
        fails++;
        $display("FAIL event: got kind %0d data %0h, expected kind %0d data %0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!clear) begin
      if (!bus.loadn) check_ev(EV_LOAD, bus.data);
      if (bus.done)   check_ev(EV_DONE, bus.data);
      if (bus.err)    check_ev(EV_ERR, bus.data);
    end
  end

  task automatic key_down(input logic [3:0] c);
    @(posedge clk);
    #1;
    bus.key_code  = c;
    bus.key_valid = 1'b1;
  endtask

  task automatic key_up();
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] c);
    key_down(c);
    repeat (10) @(posedge clk);
    key_up();
    repeat (10) @(posedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL wait_done: got no done within %0d cycles, expected done pulse", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    clear         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    #3 clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data",     32'(bus.data), 32'h000);
    check("reset_loadn",    32'(bus.loadn), 32'd1);
    check("reset_en_count", 32'(bus.en_count), 32'd0);
    check("reset_busy",     32'(bus.busy), 32'd0);
    check("reset_done_err", 32'({bus.done, bus.err}), 32'd0);
    clear = 1'b0;
    repeat (2) @(posedge clk);

    // Normal entry and run to zero
    press(4'h1); press(4'h3); press(4'h0);
    check("entry_data", 32'(bus.data), 32'h130);
    push_ev(EV_LOAD, 12'h130);
    push_ev(EV_DONE, 12'h000);
    press(4'hA);
    check("run_en_count", 32'(bus.en_count), 32'd1);
    check("run_busy",     32'(bus.busy), 32'd1);
    wait_done(200);
    check("done_idle_busy", 32'(bus.busy), 32'd0);
    check("done_idle_data", 32'(bus.data), 32'h000);
    check("done_en_count",  32'(bus.en_count), 32'd0);

    // Overflow: fourth digit dropped
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("overflow_data", 32'(bus.data), 32'h123);
    press(4'hB);
    check("cancel_entry_data", 32'(bus.data), 32'h000);
    press(4'hB);
    check("cancel_idle_data", 32'(bus.data), 32'h000);

    // Rejected START: seconds tens digit 7
    press(4'h1); press(4'h7); press(4'h5);
    push_ev(EV_ERR, 12'h175);
    press(4'hA);
    check("reject_data",  32'(bus.data), 32'h175);
    check("reject_busy",  32'(bus.busy), 32'd0);
    check("reject_loadn", 32'(bus.loadn), 32'd1);
    press(4'h9);
    check("reject_full_data", 32'(bus.data), 32'h175);
    press(4'hB);

    // Zero START in IDLE and after entering 0
    press(4'hA);
    check("start_idle_busy", 32'(bus.busy), 32'd0);
    press(4'h0);
    press(4'hA);
    check("start_zero_busy", 32'(bus.busy), 32'd0);
    check("start_zero_data", 32'(bus.data), 32'h000);
    press(4'hB);

    // Cancel while running
    press(4'h0); press(4'h4); press(4'h5);
    push_ev(EV_LOAD, 12'h045);
    press(4'hA);
    check("cancel_run_en", 32'(bus.en_count), 32'd1);
    push_ev(EV_LOAD, 12'h000);
    push_ev(EV_DONE, 12'h000);
    key_down(4'hB);
    wait_done(50);
    key_up();
    repeat (10) @(posedge clk);
    check("cancel_run_busy", 32'(bus.busy), 32'd0);
    check("cancel_run_data", 32'(bus.data), 32'h000);

    // Held key captures once
    key_down(4'h7);
    repeat (20) @(posedge clk);
    key_up();
    repeat (10) @(posedge clk);
    check("held_key_data", 32'(bus.data), 32'h007);
    press(4'hB);

`ifdef KEYPAD_DEBOUNCE_EN
    key_down(4'h5);
    repeat (2) @(posedge clk);
    #1 bus.key_valid = 1'b0;
    repeat (15) @(posedge clk);
    check("glitch_data", 32'(bus.data), 32'h000);
`endif

    // Clear mid-run
    press(4'h1); press(4'h3); press(4'h0);
    push_ev(EV_LOAD, 12'h130);
    press(4'hA);
    check("pre_clear_en", 32'(bus.en_count), 32'd1);
    @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check("clear_en_count", 32'(bus.en_count), 32'd0);
    check("clear_loadn",    32'(bus.loadn), 32'd1);
    check("clear_data",     32'(bus.data), 32'h000);
    check("clear_busy",     32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (5) @(posedge clk);

    check("events_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
